// File: rtl/cg_down_timer.sv
// Down-counting timer with one-shot and periodic modes.
// A load starts a countdown from N; when the count passes 1 the timer
// issues a single-cycle expiry pulse and either stops (one-shot) or
// restarts from the reload register (periodic). While periodic and
// running, a new load only replaces the reload value for the next period.
module cg_down_timer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [DATA_WIDTH-1:0] i_load_value,
    input  logic                  i_periodic,
    input  logic                  i_pause,
    input  logic                  i_cancel,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_busy,
    output logic                  o_expire
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_count;
    logic [DATA_WIDTH-1:0] r_reload;
    logic                  r_periodic;
    logic                  r_expire;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_count_nxt;
    logic [DATA_WIDTH-1:0] w_reload_nxt;
    logic                  w_periodic_nxt;
    logic                  w_expire_nxt;
    logic                  w_accept;
    logic [DATA_WIDTH-1:0] w_reload_src;

    // Load handshake: idle always accepts, running accepts only in periodic mode.
    always_comb begin
        o_load_ready = !i_cancel &&
                       ((r_state == ST_IDLE) || ((r_state == ST_RUN) && r_periodic));
        w_accept     = i_load_valid && o_load_ready;
        // A load arriving in the same cycle as a periodic reload wins.
        w_reload_src = w_accept ? i_load_value : r_reload;
    end

    // Next-state, count, reload and expiry decisions.
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_reload_nxt   = r_reload;
        w_periodic_nxt = r_periodic;
        w_expire_nxt   = 1'b0;

        if (i_cancel) begin
            w_count_nxt = '0;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (i_load_value != '0) begin
                            w_count_nxt    = i_load_value;
                            w_reload_nxt   = i_load_value;
                            w_periodic_nxt = i_periodic;
                            w_state_nxt    = ST_RUN;
                        end else begin
                            w_count_nxt  = '0;
                            w_expire_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        w_reload_nxt = i_load_value;
                    end
                    if (!i_pause) begin
                        if (r_count > DATA_WIDTH'(1)) begin
                            w_count_nxt = r_count - DATA_WIDTH'(1);
                        end else begin
                            w_expire_nxt = 1'b1;
                            if (r_periodic && (w_reload_src != '0)) begin
                                w_count_nxt = w_reload_src;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    w_count_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset overriding every other request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_periodic <= 1'b0;
            r_expire   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_reload   <= w_reload_nxt;
            r_periodic <= w_periodic_nxt;
            r_expire   <= w_expire_nxt;
        end
    end

    // Registered outputs.
    always_comb begin
        o_count  = r_count;
        o_busy   = (r_state == ST_RUN);
        o_expire = r_expire;
    end

endmodule

// File: tb/tb_cg_down_timer.sv
// Scoreboard bench for cg_down_timer: each stimulus cycle pushes the
// outputs expected during that cycle; a monitor pops and compares them
// on the falling edge.
module tb_cg_down_timer;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_value;
    logic         periodic;
    logic         pause;
    logic         cancel;
    logic [W-1:0] count;
    logic         busy;
    logic         expire;

    typedef struct {
        logic [W-1:0] c;
        logic         b;
        logic         e;
        logic         r;
        string        nm;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    cg_down_timer #(.DATA_WIDTH(W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_load_valid (load_valid),
        .o_load_ready (load_ready),
        .i_load_value (load_value),
        .i_periodic   (periodic),
        .i_pause      (pause),
        .i_cancel     (cancel),
        .o_count      (count),
        .o_busy       (busy),
        .o_expire     (expire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the cycle's outputs against the expected entry.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests_run++;
            if (count !== e.c || busy !== e.b || expire !== e.e || load_ready !== e.r) begin
                tests_failed++;
                $display("FAIL %s: got count=%0d busy=%0b expire=%0b ready=%0b, expected count=%0d busy=%0b expire=%0b ready=%0b",
                         e.nm, count, busy, expire, load_ready, e.c, e.b, e.e, e.r);
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic t(input logic r, input logic v, input logic [W-1:0] val,
                     input logic per, input logic pau, input logic can,
                     input logic [W-1:0] c, input logic b, input logic e,
                     input logic rdy, input string nm);
        exp_t x;
        rst        = r;
        load_valid = v;
        load_value = val;
        periodic   = per;
        pause      = pau;
        cancel     = can;
        x.c = c; x.b = b; x.e = e; x.r = rdy; x.nm = nm;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_value = '0;
        periodic = 1'b0; pause = 1'b0; cancel = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        //  rst v  val per pau can   cnt b  e  rdy
        // Reset: ready visible, load ignored
        t(1, 1, 8'd5, 0, 0, 0,   8'd0, 0, 0, 1, "rst_ready");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "rst_state");
        // One-shot load 3
        t(0, 1, 8'd3, 0, 0, 0,   8'd0, 0, 0, 1, "os_load");
        t(0, 0, 8'd0, 0, 0, 0,   8'd3, 1, 0, 0, "os_c3");
        t(0, 0, 8'd0, 0, 0, 0,   8'd2, 1, 0, 0, "os_c2");
        t(0, 0, 8'd0, 0, 0, 0,   8'd1, 1, 0, 0, "os_c1");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 1, 1, "os_expire");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "os_after");
        // Periodic load 4
        t(0, 1, 8'd4, 1, 0, 0,   8'd0, 0, 0, 1, "per_load");
        t(0, 0, 8'd0, 0, 0, 0,   8'd4, 1, 0, 1, "per_c4");
        t(0, 0, 8'd0, 0, 0, 0,   8'd3, 1, 0, 1, "per_c3");
        t(0, 0, 8'd0, 0, 0, 0,   8'd2, 1, 0, 1, "per_c2");
        t(0, 0, 8'd0, 0, 0, 0,   8'd1, 1, 0, 1, "per_c1");
        t(0, 0, 8'd0, 0, 0, 0,   8'd4, 1, 1, 1, "per_exp1");
        t(0, 0, 8'd0, 0, 0, 0,   8'd3, 1, 0, 1, "per_b3");
        t(0, 0, 8'd0, 0, 0, 0,   8'd2, 1, 0, 1, "per_b2");
        t(0, 0, 8'd0, 0, 0, 0,   8'd1, 1, 0, 1, "per_b1");
        t(0, 0, 8'd0, 0, 0, 0,   8'd4, 1, 1, 1, "per_exp2");
        t(0, 0, 8'd0, 0, 0, 0,   8'd3, 1, 0, 1, "per_d3");
        // Reload update to 2 while counting: current period unaffected
        t(0, 1, 8'd2, 0, 0, 0,   8'd2, 1, 0, 1, "upd_load2");
        t(0, 0, 8'd0, 0, 0, 0,   8'd1, 1, 0, 1, "upd_c1");
        t(0, 0, 8'd0, 0, 0, 0,   8'd2, 1, 1, 1, "upd_exp");
        t(0, 0, 8'd0, 0, 0, 0,   8'd1, 1, 0, 1, "p2_c1");
        t(0, 0, 8'd0, 0, 0, 0,   8'd2, 1, 1, 1, "p2_exp");
        // Load coinciding with reload: new value goes into count
        t(0, 1, 8'd3, 0, 0, 0,   8'd1, 1, 0, 1, "same_load3");
        t(0, 0, 8'd0, 0, 0, 0,   8'd3, 1, 1, 1, "same_exp");
        t(0, 0, 8'd0, 0, 0, 0,   8'd2, 1, 0, 1, "same_c2");
        // Load 0 at reload: expire then idle
        t(0, 1, 8'd0, 0, 0, 0,   8'd1, 1, 0, 1, "zrel_load0");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 1, 1, "zrel_exp");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "zrel_idle");
        // Zero load in idle: single pulse, stays idle
        t(0, 1, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "zero_load");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 1, 1, "zero_exp");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "zero_once");
        // Pause at 3 for 2 cycles, cancel at 2
        t(0, 1, 8'd5, 0, 0, 0,   8'd0, 0, 0, 1, "pc_load5");
        t(0, 0, 8'd0, 0, 0, 0,   8'd5, 1, 0, 0, "pc_c5");
        t(0, 0, 8'd0, 0, 0, 0,   8'd4, 1, 0, 0, "pc_c4");
        t(0, 0, 8'd0, 0, 1, 0,   8'd3, 1, 0, 0, "pc_pause1");
        t(0, 0, 8'd0, 0, 1, 0,   8'd3, 1, 0, 0, "pc_pause2");
        t(0, 0, 8'd0, 0, 0, 0,   8'd3, 1, 0, 0, "pc_held3");
        t(0, 0, 8'd0, 0, 0, 1,   8'd2, 1, 0, 0, "pc_cancel");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "pc_idle");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "pc_noexp");
        // Cancel with load in idle
        t(0, 1, 8'd6, 0, 0, 1,   8'd0, 0, 0, 0, "can_ready");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "can_noload");
        // Reset mid-countdown at 7
        t(0, 1, 8'd9, 1, 0, 0,   8'd0, 0, 0, 1, "rr_load9");
        t(0, 0, 8'd0, 0, 0, 0,   8'd9, 1, 0, 1, "rr_c9");
        t(0, 0, 8'd0, 0, 0, 0,   8'd8, 1, 0, 1, "rr_c8");
        t(1, 1, 8'd3, 0, 0, 0,   8'd7, 1, 0, 1, "rr_c7");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "rr_reset");
        // Full-scale value
        t(0, 1, 8'd255, 0, 0, 0, 8'd0, 0, 0, 1, "max_load");
        t(0, 0, 8'd0, 0, 0, 0,   8'd255, 1, 0, 0, "max_c255");
        t(0, 0, 8'd0, 0, 0, 1,   8'd254, 1, 0, 0, "max_c254");
        t(0, 0, 8'd0, 0, 0, 0,   8'd0, 0, 0, 1, "max_idle");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
